// File: rtl/conv_mem_arbiter.sv
// conv_mem_arbiter: two-requester arbiter in front of the conv layer memories.
// Requester A is the conv writer, requester B the maxpool engine. Each cycle at
// most one request is granted (combinational gnt); the accepted request becomes
// a registered memory command the next cycle. Reads return rvalid to their owner
// two cycles after acceptance, with rdata a straight copy of cdata_rd.
// Ownership can be retained with lock, bounded by a starvation counter so a
// locked owner cannot hold the memory for more than STARVE_MAX grants while the
// other side waits.
// Ports:
//   clk, reset (async, active-high)
//   a_*/b_*  : req, we, lock, sel, addr, wdata in; gnt, rvalid, rdata out
//   cwr/crd/csel/caddr_wr/cdata_wr/caddr_rd : registered memory command
//   cdata_rd : memory read data, valid the cycle after crd
module conv_mem_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 20,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [2:0]    a_sel,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [2:0]    b_sel,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          cwr,
  output logic          crd,
  output logic [2:0]    csel,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state, state_nxt;
  logic          ptr, ptr_nxt;          // 0 = A next on contention, 1 = B
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] cnt_base, cnt_inc;
  logic          ga, gb, g_any, g_we, g_lock, other_req, starve;
  logic [2:0]    g_sel;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic          rd_a_d1, rd_b_d1;      // read accepted last cycle, per owner

  // Grant decision
  always_comb begin
    ga = 1'b0;
    gb = 1'b0;
    case (state)
      IDLE: begin
        if (a_req && b_req) begin
          ga = ~ptr;
          gb = ptr;
        end else begin
          ga = a_req;
          gb = b_req;
        end
      end
      OWN_A:   ga = a_req;
      OWN_B:   gb = b_req;
      default: ;
    endcase
    if (reset) begin
      ga = 1'b0;
      gb = 1'b0;
    end
  end

  assign a_gnt   = ga;
  assign b_gnt   = gb;
  assign g_any   = ga | gb;
  assign g_we    = gb ? b_we    : a_we;
  assign g_lock  = gb ? b_lock  : a_lock;
  assign g_sel   = gb ? b_sel   : a_sel;
  assign g_addr  = gb ? b_addr  : a_addr;
  assign g_wdata = gb ? b_wdata : a_wdata;
  assign a_rdata = cdata_rd;
  assign b_rdata = cdata_rd;

  // Streak only continues when the grant stays with the current owner; a grant
  // from IDLE starts a fresh ownership, so it counts from zero.
  assign other_req = ga ? b_req : a_req;
  assign cnt_base  = ((ga && state == OWN_A) || (gb && state == OWN_B)) ? cnt : '0;
  assign cnt_inc   = cnt_base + CW'(1);
  assign starve    = other_req && (cnt_inc >= CW'(STARVE_MAX));

  // Next state; releasing always hands the pointer to the side just not served
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    if (g_any) begin
      if (!g_lock || starve) begin
        state_nxt = IDLE;
        ptr_nxt   = ga;
        cnt_nxt   = '0;
      end else begin
        state_nxt = ga ? OWN_A : OWN_B;
        cnt_nxt   = other_req ? cnt_inc : '0;
      end
    end else if (state != IDLE) begin
      state_nxt = IDLE;
      ptr_nxt   = (state == OWN_A);
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Memory command and read-return pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwr      <= 1'b0;
      crd      <= 1'b0;
      csel     <= 3'b000;
      caddr_wr <= '0;
      cdata_wr <= '0;
      caddr_rd <= '0;
      rd_a_d1  <= 1'b0;
      rd_b_d1  <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      cwr      <= g_any & g_we;
      crd      <= g_any & ~g_we;
      csel     <= g_any ? g_sel : 3'b000;
      if (g_any && g_we) begin
        caddr_wr <= g_addr;
        cdata_wr <= g_wdata;
      end
      if (g_any && !g_we) caddr_rd <= g_addr;
      rd_a_d1  <= ga & ~a_we;
      rd_b_d1  <= gb & ~b_we;
      a_rvalid <= rd_a_d1;
      b_rvalid <= rd_b_d1;
    end
  end
endmodule

// File: tb/tb_conv_mem_arbiter.sv
module tb_conv_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 20;
  localparam int SM = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 0, a_we = 0, a_lock = 0;
  logic [2:0]    a_sel = 0;
  logic [AW-1:0] a_addr = 0;
  logic [DW-1:0] a_wdata = 0;
  logic          b_req = 0, b_we = 0, b_lock = 0;
  logic [2:0]    b_sel = 0;
  logic [AW-1:0] b_addr = 0;
  logic [DW-1:0] b_wdata = 0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, cwr, crd;
  logic [DW-1:0] a_rdata, b_rdata, cdata_wr;
  logic [DW-1:0] cdata_rd = 0;
  logic [2:0]    csel;
  logic [AW-1:0] caddr_wr, caddr_rd;

  int nvec = 0;
  int nerr = 0;

  conv_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_sel(a_sel), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_sel(b_sel), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .cwr(cwr), .crd(crd), .csel(csel), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .caddr_rd(caddr_rd), .cdata_rd(cdata_rd)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the memory, whose turn it is on contention,
  // and how long the current owner has been served while the other waited.
  int            m_owner;   // 0 none, 1 A, 2 B
  int            m_turn;    // 0 A, 1 B
  int            m_streak;
  bit            ex_ga, ex_gb;
  bit            e_cwr, e_crd;
  logic [2:0]    e_csel;
  logic [AW-1:0] e_caw, e_car;
  logic [DW-1:0] e_cdw;
  int            e_rd1, e_rv;  // owner of read issued last cycle / returning now

  task automatic model_reset();
    m_owner = 0; m_turn = 0; m_streak = 0;
    e_cwr = 0; e_crd = 0; e_csel = 0; e_caw = 0; e_car = 0; e_cdw = 0;
    e_rd1 = 0; e_rv = 0;
  endtask

  task automatic model_eval();
    ex_ga = 0; ex_gb = 0;
    if (m_owner == 1) ex_ga = a_req;
    else if (m_owner == 2) ex_gb = b_req;
    else if (a_req && b_req) begin
      if (m_turn == 0) ex_ga = 1; else ex_gb = 1;
    end else begin
      ex_ga = a_req; ex_gb = b_req;
    end
  endtask

  task automatic model_clock();
    int me;
    bit oreq, lk, we;
    e_rv = e_rd1; e_rd1 = 0; e_cwr = 0; e_crd = 0; e_csel = 0;
    if (ex_ga || ex_gb) begin
      me   = ex_ga ? 1 : 2;
      we   = ex_ga ? a_we : b_we;
      lk   = ex_ga ? a_lock : b_lock;
      oreq = ex_ga ? b_req : a_req;
      e_csel = ex_ga ? a_sel : b_sel;
      if (we) begin
        e_cwr = 1; e_caw = ex_ga ? a_addr : b_addr; e_cdw = ex_ga ? a_wdata : b_wdata;
      end else begin
        e_crd = 1; e_car = ex_ga ? a_addr : b_addr; e_rd1 = me;
      end
      if (m_owner != me) m_streak = 0;
      m_streak = oreq ? m_streak + 1 : 0;
      if (!lk || m_streak >= SM) begin
        m_owner = 0; m_turn = (me == 1) ? 1 : 0; m_streak = 0;
      end else m_owner = me;
    end else if (m_owner != 0) begin
      m_turn = (m_owner == 1) ? 1 : 0; m_owner = 0; m_streak = 0;
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk); #1;
    cdata_rd = DW'($urandom);
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_lock = 0; a_sel = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_lock = 0; b_sel = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  function automatic logic [2:0] pick_sel();
    int r = $urandom_range(0, 2);
    return (r == 0) ? 3'b000 : (r == 1) ? 3'b001 : 3'b011;
  endfunction

  task automatic test_reset();
    reset = 1; a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    #2;
    nvec++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, cwr, crd, csel, caddr_wr, cdata_wr, caddr_rd} !== '0) begin
      nerr++; $display("FAIL reset_outputs: gnt=%b%b cwr=%b crd=%b csel=%b exp all zero", a_gnt, b_gnt, cwr, crd, csel);
    end
    @(posedge clk); #1;
    reset = 0; model_reset();
    settle();
    nvec++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      nerr++; $display("FAIL first_grant: got a=%b b=%b exp a=1 b=0", a_gnt, b_gnt);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_write_a();
    apply_reset();
    a_req = 1; a_we = 1; a_sel = 3'b001; a_addr = 12'h005; a_wdata = 20'h00123;
    settle();
    nvec++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      nerr++; $display("FAIL wr_gnt: got a=%b b=%b exp a=1 b=0", a_gnt, b_gnt);
    end
    step();
    a_req = 0;
    settle();
    nvec++;
    if ({cwr, crd, csel, caddr_wr, cdata_wr} !== {1'b1, 1'b0, 3'b001, 12'h005, 20'h00123}) begin
      nerr++; $display("FAIL wr_cmd: got cwr=%b crd=%b csel=%b addr=%h data=%h exp 1 0 001 005 00123", cwr, crd, csel, caddr_wr, cdata_wr);
    end
    step();
    settle();
    nvec++;
    if ({cwr, csel, caddr_wr, cdata_wr} !== {1'b0, 3'b000, 12'h005, 20'h00123}) begin
      nerr++; $display("FAIL wr_after: got cwr=%b csel=%b addr=%h data=%h exp 0 000 005 00123", cwr, csel, caddr_wr, cdata_wr);
    end
    step();
  endtask

  task automatic test_read_b();
    apply_reset();
    b_req = 1; b_we = 0; b_sel = 3'b001; b_addr = 12'h041;
    settle();
    nvec++;
    if ({a_gnt, b_gnt} !== 2'b01) begin
      nerr++; $display("FAIL rd_gnt: got a=%b b=%b exp a=0 b=1", a_gnt, b_gnt);
    end
    step();
    b_req = 0;
    settle();
    nvec++;
    if ({crd, cwr, csel, caddr_rd} !== {1'b1, 1'b0, 3'b001, 12'h041}) begin
      nerr++; $display("FAIL rd_cmd: got crd=%b cwr=%b csel=%b addr=%h exp 1 0 001 041", crd, cwr, csel, caddr_rd);
    end
    step();
    settle();
    nvec++;
    if ({b_rvalid, a_rvalid} !== 2'b10 || b_rdata !== cdata_rd) begin
      nerr++; $display("FAIL rd_return: got b_rv=%b a_rv=%b rdata=%h exp 1 0 %h", b_rvalid, a_rvalid, b_rdata, cdata_rd);
    end
    step();
    settle();
    nvec++;
    if ({b_rvalid, a_rvalid} !== 2'b00) begin
      nerr++; $display("FAIL rd_single: got b_rv=%b a_rv=%b exp 0 0", b_rvalid, a_rvalid);
    end
    step();
  endtask

  task automatic test_alternate();
    apply_reset();
    a_req = 1; a_we = 1; a_sel = 3'b001; b_req = 1; b_we = 1; b_sel = 3'b011;
    for (int i = 0; i < 8; i++) begin
      settle();
      nvec++;
      if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        nerr++; $display("FAIL alt_gnt[%0d]: got a=%b b=%b exp %s", i, a_gnt, b_gnt, (i % 2 == 0) ? "A" : "B");
      end
      if (i > 0) begin
        nvec++;
        if (csel !== ((i % 2 == 1) ? 3'b001 : 3'b011)) begin
          nerr++; $display("FAIL alt_csel[%0d]: got %b exp %b", i, csel, (i % 2 == 1) ? 3'b001 : 3'b011);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_starve();
    apply_reset();
    a_req = 1; a_we = 1; a_lock = 1; a_sel = 3'b001;
    b_req = 1; b_we = 1; b_lock = 0; b_sel = 3'b011;
    for (int i = 0; i < SM + 3; i++) begin
      settle();
      nvec++;
      if ({a_gnt, b_gnt} !== ((i == SM) ? 2'b01 : 2'b10)) begin
        nerr++; $display("FAIL starve_gnt[%0d]: got a=%b b=%b exp %s", i, a_gnt, b_gnt, (i == SM) ? "B" : "A");
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    b_req = 1; b_we = 0; b_sel = 3'b001; b_addr = 12'h041;
    settle();
    step();
    b_req = 0;
    settle();
    nvec++;
    if (crd !== 1'b1) begin
      nerr++; $display("FAIL mid_rdcmd: got crd=%b exp 1", crd);
    end
    reset = 1;
    a_req = 1; a_we = 1; b_req = 1; b_we = 1;
    #1;
    nvec++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, cwr, crd, csel, caddr_wr, cdata_wr, caddr_rd} !== '0) begin
      nerr++; $display("FAIL mid_reset_outputs: gnt=%b%b rv=%b%b crd=%b addr_rd=%h exp all zero", a_gnt, b_gnt, a_rvalid, b_rvalid, crd, caddr_rd);
    end
    @(posedge clk); #1;
    reset = 0; model_reset();
    settle();
    nvec++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b1000) begin
      nerr++; $display("FAIL mid_after: got gnt=%b%b rv=%b%b exp gnt=10 rv=00", a_gnt, b_gnt, a_rvalid, b_rvalid);
    end
    step();
    settle();
    nvec++;
    if ({a_rvalid, b_rvalid, cwr} !== 3'b001) begin
      nerr++; $display("FAIL mid_norv: got rv=%b%b cwr=%b exp rv=00 cwr=1", a_rvalid, b_rvalid, cwr);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      settle();
      nvec++;
      if ({a_gnt, b_gnt} !== {ex_ga, ex_gb}) begin
        nerr++; $display("FAIL rnd_gnt[%0d]: got %b%b exp %b%b", i, a_gnt, b_gnt, ex_ga, ex_gb);
      end
      nvec++;
      if ({cwr, crd, csel} !== {e_cwr, e_crd, e_csel}) begin
        nerr++; $display("FAIL rnd_cmd[%0d]: got cwr=%b crd=%b csel=%b exp %b %b %b", i, cwr, crd, csel, e_cwr, e_crd, e_csel);
      end
      nvec++;
      if ({caddr_wr, cdata_wr, caddr_rd} !== {e_caw, e_cdw, e_car}) begin
        nerr++; $display("FAIL rnd_addr[%0d]: got aw=%h dw=%h ar=%h exp %h %h %h", i, caddr_wr, cdata_wr, caddr_rd, e_caw, e_cdw, e_car);
      end
      nvec++;
      if ({a_rvalid, b_rvalid} !== {e_rv == 1, e_rv == 2}) begin
        nerr++; $display("FAIL rnd_rvalid[%0d]: got %b%b exp %b%b", i, a_rvalid, b_rvalid, e_rv == 1, e_rv == 2);
      end
      if (e_rv != 0) begin
        nvec++;
        if ((e_rv == 1 ? a_rdata : b_rdata) !== cdata_rd) begin
          nerr++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", i, e_rv == 1 ? a_rdata : b_rdata, cdata_rd);
        end
      end
      step();
      // A pending request must hold its fields until granted
      if (!a_req || ex_ga) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1);
        a_lock = ($urandom_range(0, 3) != 0); a_sel = pick_sel();
        a_addr = AW'($urandom); a_wdata = DW'($urandom);
      end
      if (!b_req || ex_gb) begin
        b_req = ($urandom_range(0, 3) != 0); b_we = $urandom_range(0, 1);
        b_lock = ($urandom_range(0, 1) != 0); b_sel = pick_sel();
        b_addr = AW'($urandom); b_wdata = DW'($urandom);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_a();
    test_read_b();
    test_alternate();
    test_starve();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/conv_mem_arbiter.md
CONV_MEM_ARBITER -- requirements
Module: conv_mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AW, 12, address width.
- DW, 20, data width.
- STARVE_MAX, 8, maximum consecutive locked grants to one requester while the other is requesting.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, the only clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-high.
- a_req / b_req, in, 1, request (A = conv writer, B = maxpool engine).
- a_we / b_we, in, 1, 1 = write, 0 = read.
- a_lock / b_lock, in, 1, request to retain ownership after this grant.
- a_sel / b_sel, in, 3, memory select (000 none, 001 layer0, 011 layer1).
- a_addr / b_addr, in, AW, address.
- a_wdata / b_wdata, in, DW, write data.
- a_gnt / b_gnt, out, 1, combinational; request accepted this cycle.
- a_rvalid / b_rvalid, out, 1, registered; read data valid.
- a_rdata / b_rdata, out, DW, combinational copy of cdata_rd.
- cwr, out, 1, memory write strobe.
- crd, out, 1, memory read strobe.
- csel, out, 3, memory select.
- caddr_wr, out, AW, write address.
- cdata_wr, out, DW, write data.
- caddr_rd, out, AW, read address.
- cdata_rd, in, DW, read data; valid the cycle after crd.

REQ-003 The clock port SHALL be named clk and the reset port reset; there is one clock, and reset is asynchronous and active-high.

Function
REQ-004 A requester SHALL hold req and all its fields stable until it sees gnt high; a request is accepted in any cycle where req and gnt are both high.
REQ-005 At most one gnt SHALL be high per cycle; gnt SHALL be high only while the corresponding req is high.
REQ-006 Each accepted request SHALL produce exactly one memory command, registered, in the next cycle:
- Write: cwr=1, crd=0, csel=sel, caddr_wr=addr, cdata_wr=wdata.
- Read: crd=1, cwr=0, csel=sel, caddr_rd=addr.
REQ-007 In cycles with no command, cwr=0, crd=0 and csel=000; caddr_*/cdata_wr hold their last values.
REQ-008 For a read accepted in cycle N, the owner's rvalid SHALL be high in cycle N+2 only, with rdata=cdata_rd; the other requester's rvalid stays 0.
REQ-009 States SHALL be IDLE, OWN_A and OWN_B, with a 1-bit round-robin pointer (reset value = A first).
REQ-010 IDLE transitions:
- Grant the sole requester.
- If both request, grant the pointer side.
- If none request, remain IDLE.
REQ-011 After each grant:
- With lock=1: go to/stay in OWN_x.
- With lock=0: return to IDLE and set the pointer to the other requester.
REQ-012 In OWN_x, x SHALL be granted whenever x_req=1, and the other requester SHALL not be granted.
REQ-013 OWN_x SHALL be left to IDLE, with the pointer set to the other requester, when any of these holds:
- x_req=0 for one cycle.
- A grant carries lock=0.
- The starvation counter releases it (REQ-014).
REQ-014 Starvation counter:
- Counts consecutive grants within one ownership while the other requester's req=1.
- Clears on ownership change or when the other req=0.
- On reaching STARVE_MAX, forces release after that grant regardless of lock.
REQ-015 Throughput: with continuous requests, one command per cycle, including across ownership changes; the change takes no idle bubble.
REQ-016 Read and write commands to the same address in consecutive cycles SHALL be issued in acceptance order, with no reordering or merging.
REQ-017 sel=000 with req=1 SHALL still be granted and consume a slot, issuing cwr/crd with csel=000.

Reset
REQ-018 While reset=1, asynchronously:
- All registered outputs = 0, state = IDLE, pointer = A, counter = 0.
- gnt outputs = 0.
REQ-019 Reset asserted mid-operation SHALL discard any pending command and rvalid; none appears after release.
REQ-020 The first grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-021 A write (sel=001, addr=0x005, wdata=0x00123), A only, accepted in cycle N -> cycle N+1: cwr=1, csel=001, caddr_wr=0x005, cdata_wr=0x00123; cycle N+2: cwr=0, csel=000.
REQ-022 B read (sel=001, addr=0x041) accepted in cycle N -> cycle N+1: crd=1, caddr_rd=0x041; cycle N+2: b_rvalid=1, b_rdata=cdata_rd, a_rvalid=0.
REQ-023 Both requesting continuously from reset, lock=0 -> grants alternate A,B,A,B, one per cycle, and csel never drops to 000.
REQ-024 a_lock=1 and both requesting, STARVE_MAX=8 -> 8 consecutive A grants, then 1 B grant, then A again.
REQ-025 reset pulsed in the cycle between a read command and its rvalid -> all outputs 0 immediately; no rvalid after release; next grant goes to A if both request.
